// File: rtl/addsub_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
package addsub_pkg;
   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

   localparam int          DEF_WIDTH = 8;
   localparam int          DEF_NREQ  = 4;
   localparam logic [15:0] OPS_MAX   = 16'hFFFF;
endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/sub; MSB of y is carry (add) or borrow (sub).
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH:0]   y
);
   always_comb begin
      if (op == OP_SUB) y = {1'b0, a} - {1'b0, b};
      else              y = {1'b0, a} + {1'b0, b};
   end
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath across NREQ requesters,
// with a single-entry result register and a saturating transfer counter.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREQ  = DEF_NREQ,
   localparam int IDW   = $clog2(NREQ)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
   input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
   input  logic [NREQ-1:0]             req_op,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [WIDTH:0]              res_data,
   output logic [IDW-1:0]              res_id,
   output logic [15:0]                 ops_done
);
   logic [IDW-1:0] ptr, win, ptr_nxt;
   logic           any_vld, can_issue, grant;
   logic [WIDTH:0] core_y;

   // Scan from the farthest slot back toward ptr so the nearest valid one wins.
   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      any_vld = 1'b0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[IDW'(idx)]) begin
            win     = IDW'(idx);
            any_vld = 1'b1;
         end
      end
   end

   assign can_issue = !res_valid || res_ready;
   // rst_n gating keeps req_ready low for the whole reset window, not just after an edge.
   assign grant     = rst_n && can_issue && any_vld;
   assign ptr_nxt   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win] = 1'b1;
   end

   addsub_core #(.WIDTH(WIDTH)) u_core (
      .a  (req_a[win]),
      .b  (req_b[win]),
      .op (op_e'(req_op[win])),
      .y  (core_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         ops_done  <= '0;
      end else begin
         if (res_valid && res_ready && ops_done != OPS_MAX)
            ops_done <= ops_done + 16'd1;
         if (grant) begin
            res_valid <= 1'b1;
            res_data  <= core_y;
            res_id    <= win;
            ptr       <= ptr_nxt;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (WIDTH=8, NREQ=4) with hand-computed expectations.
module tb_addsub_arbiter;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req_valid, req_ready, req_op;
   logic [3:0][7:0]  req_a, req_b;
   logic             res_valid, res_ready;
   logic [8:0]       res_data;
   logic [1:0]       res_id;
   logic [15:0]      ops_done;
   int               total = 0;
   int               bad   = 0;

   addsub_arbiter #(.WIDTH(8), .NREQ(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n = 1'b1; res_ready = 1'b1;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      #2 rst_n = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_data",  res_data,  0);
      chk("rst_id",    res_id,    0);
      chk("rst_ops",   ops_done,  0);
      chk("rst_ready", req_ready, 0);
      req_valid = '0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      tick();

      // add with carry out
      req_a[0] = 8'hFF; req_b[0] = 8'h01; req_op[0] = 1'b0; req_valid = 4'b0001;
      #1 chk("add_ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      chk("add_valid", res_valid, 1);
      chk("add_data",  res_data,  9'h100);
      chk("add_id",    res_id,    0);
      chk("add_ops",   ops_done,  0);
      tick();
      chk("drain_valid", res_valid, 0);
      chk("drain_hold",  res_data,  9'h100);
      chk("drain_ops",   ops_done,  1);

      // sub with borrow, then plain sub
      req_a[2] = 8'h00; req_b[2] = 8'h01; req_op[2] = 1'b1; req_valid = 4'b0100;
      #1 chk("sub_ready", req_ready, 4'b0100);
      tick(); req_valid = '0;
      chk("sub_data", res_data, 9'h1FF);
      chk("sub_id",   res_id,   2);
      tick();
      req_a[2] = 8'h05; req_b[2] = 8'h03; req_valid = 4'b0100;
      tick(); req_valid = '0;
      chk("sub2_data", res_data, 9'h002);
      chk("sub2_id",   res_id,   2);
      tick();
      chk("sub2_ops", ops_done, 3);

      // operands: A = 0x10*i, B = i, add -> result 0x11*i
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 8'(16*i); req_b[i] = 8'(i); req_op[i] = 1'b0;
      end
      req_valid = 4'b1000;
      tick(); req_valid = '0;
      chk("r3_id",   res_id,   3);
      chk("r3_data", res_data, 9'h033);
      tick();
      chk("r3_ops", ops_done, 4);

      // full throughput round robin
      req_valid = 4'hF;
      #1 chk("rr_ready0", req_ready, 4'b0001);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_valid", res_valid, 1);
         chk("rr_id",    res_id,    k % 4);
         chk("rr_data",  res_data,  17 * (k % 4));
         chk("rr_ops",   ops_done,  4 + k);
         chk("rr_ready", req_ready, 1 << ((k + 1) % 4));
      end

      // backpressure: result id1 held
      res_ready = 1'b0;
      #1 chk("bp_ready", req_ready, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_valid", res_valid, 1);
         chk("bp_id",    res_id,    1);
         chk("bp_data",  res_data,  9'h011);
         chk("bp_ready", req_ready, 0);
         chk("bp_ops",   ops_done,  9);
      end
      res_ready = 1'b1;
      #1 chk("bp_regrant", req_ready, 4'b0100);
      tick();
      chk("bp_id2",  res_id,   2);
      chk("bp_ops2", ops_done, 10);

      // mid-stream reset with ptr=3
      rst_n = 1'b0; req_valid = 4'b1010;
      #1;
      chk("mrst_valid", res_valid, 0);
      chk("mrst_data",  res_data,  0);
      chk("mrst_id",    res_id,    0);
      chk("mrst_ops",   ops_done,  0);
      chk("mrst_ready", req_ready, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_ready", req_ready, 4'b0010);
      tick();
      chk("post_id",   res_id,   1);
      chk("post_data", res_data, 9'h011);
      chk("post_ops",  ops_done, 0);
      chk("post_rdy3", req_ready, 4'b1000);
      tick(); req_valid = '0;
      chk("post_id3", res_id,   3);
      chk("post_d3",  res_data, 9'h033);
      chk("post_ops1", ops_done, 1);
      tick();
      chk("post_ops2", ops_done, 2);

      // saturation
      req_valid = 4'hF;
      n = 0;
      while (ops_done != 16'hFFFE && n < 70000) begin
         tick();
         n++;
      end
      chk("sat_preload", ops_done, 16'hFFFE);
      tick(); tick(); tick();
      chk("sat_max", ops_done, 16'hFFFF);
      tick();
      chk("sat_hold", ops_done, 16'hFFFF);
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
